// File: rtl/ucsie_rx_credit_buffer_if.sv
// Beat stream bundle shared by the PHY-side input and protocol-side output of the RX credit buffer.
// The master drives a beat with framing; the slave answers with ready.
interface ucsie_rx_credit_buffer_if #(
   parameter int DATA_W = 256
);
   logic                  valid;
   logic                  ready;
   logic [DATA_W-1:0]     data;
   logic [DATA_W/8-1:0]   strb;
   logic                  sop;
   logic                  eop;

   modport master (output valid, data, strb, sop, eop, input ready);
   modport slave  (input valid, data, strb, sop, eop, output ready);
endinterface

// File: rtl/ucsie_rx_credit_buffer.sv
// Receive end of the adapter<->PHY credit loop: credit-sized FWFT FIFO, protocol-side valid/ready
// delivery, and batched return of freed credits to the remote transmitter.
module ucsie_rx_credit_buffer #(
   parameter int DATA_W       = 256,
   parameter int DEPTH        = 16,
   parameter int CREDIT_W     = 8,
   parameter int RET_THRESH   = 4,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    link_ready,
   ucsie_rx_credit_buffer_if.slave  phy,
   ucsie_rx_credit_buffer_if.master rx,
   output logic                    credit_return_valid,
   output logic [CREDIT_W-1:0]     credit_return_cnt,
   output logic                    err_overflow,
   output logic                    err_framing,
   input  logic                    err_clr
);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PEND_W = $clog2(DEPTH + 2);
   localparam int TMR_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int ENT_W  = DATA_W + DATA_W/8 + 2;

   typedef enum logic [1:0] {DOWN, ADVERT, RUN} state_t;

   state_t              state, state_d;
   logic [ENT_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                in_pkt;
   logic [PEND_W-1:0]   pending, pending_d;
   logic [TMR_W-1:0]    timer, timer_d;
   logic                ret_valid_d;
   logic [CREDIT_W-1:0] ret_cnt_d;
   logic                run, full, pop, accept, stray, ovf, drop, push, bad_sop;
   logic [1:0]          inc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign run     = (state == RUN) && link_ready;
   assign full    = (count == CNT_W'(DEPTH));
   assign rx.valid = (count != '0);
   assign pop     = rx.valid && rx.ready;
   assign accept  = run && phy.valid;
   assign stray   = accept && !in_pkt && !phy.sop;
   assign bad_sop = accept && in_pkt && phy.sop;
   // A pop in the same cycle frees the slot, so only a full FIFO without a pop drops.
   assign ovf     = accept && full && !pop;
   assign drop    = stray || ovf;
   assign push    = accept && !drop;
   assign inc     = {1'b0, pop} + {1'b0, drop};
   assign phy.ready = 1'b1;
   assign {rx.data, rx.strb, rx.sop, rx.eop} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= DOWN;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (!link_ready) begin
         state_d = DOWN;
      end else begin
         case (state)
            DOWN:    state_d = ADVERT;
            ADVERT:  state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // Next-cycle credit return is decided here and registered, so the pulse lines up with the
   // cycle whose registered pending/timer satisfy the firing rule.
   always_comb begin
      pending_d   = '0;
      timer_d     = '0;
      ret_valid_d = 1'b0;
      ret_cnt_d   = '0;
      if (run) begin
         if (credit_return_valid) begin
            pending_d = PEND_W'(inc);
         end else begin
            pending_d = pending + PEND_W'(inc);
            if ((pending != '0) && (pending < PEND_W'(RET_THRESH))) timer_d = timer + 1'b1;
         end
      end
      if (state_d == ADVERT) begin
         ret_valid_d = 1'b1;
         ret_cnt_d   = CREDIT_W'(DEPTH);
      end else if ((state_d == RUN) &&
                   ((pending_d >= PEND_W'(RET_THRESH)) ||
                    ((pending_d != '0) && (timer_d == TMR_W'(IDLE_TIMEOUT - 1))))) begin
         ret_valid_d = 1'b1;
         ret_cnt_d   = CREDIT_W'(pending_d);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {phy.data, phy.strb, phy.sop, phy.eop};
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !link_ready) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         in_pkt  <= 1'b0;
         pending <= '0;
         timer   <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push) in_pkt <= phy.eop ? 1'b0 : (phy.sop | in_pkt);
         pending <= pending_d;
         timer   <= timer_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_return_valid <= 1'b0;
         credit_return_cnt   <= '0;
         err_overflow        <= 1'b0;
         err_framing         <= 1'b0;
      end else begin
         credit_return_valid <= ret_valid_d;
         credit_return_cnt   <= ret_cnt_d;
         if (ovf)          err_overflow <= 1'b1;
         else if (err_clr) err_overflow <= 1'b0;
         if (stray || bad_sop) err_framing <= 1'b1;
         else if (err_clr)     err_framing <= 1'b0;
      end
   end
endmodule
